// File: rtl/bilinear_interp_2d_if.sv
// Stream bundle for bilinear_interp_2d: neighbourhood/fraction input side
// and interpolated-pixel output side, each with valid/ready handshake.
interface bilinear_interp_2d_if #(
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = 2,
    parameter int NUM_CH    = 1,
    parameter int USER_W    = 1
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CH*4*PIX_W-1:0]  in_pixels;
    logic [FRAC_BITS-1:0]       in_frac_x;
    logic [FRAC_BITS-1:0]       in_frac_y;
    logic [USER_W-1:0]          in_user;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CH*PIX_W-1:0]    out_pixel;
    logic [USER_W-1:0]          out_user;

    // Upstream fetch stage / downstream writer side.
    modport master (
        output in_valid, in_pixels, in_frac_x, in_frac_y, in_user, out_ready,
        input  in_ready, out_valid, out_pixel, out_user
    );

    // Interpolator side.
    modport slave (
        input  in_valid, in_pixels, in_frac_x, in_frac_y, in_user, out_ready,
        output in_ready, out_valid, out_pixel, out_user
    );
endinterface

// File: rtl/bilinear_interp_2d.sv
// Three-stage pipelined 2D bilinear interpolator with valid/ready backpressure.
// Define BILINEAR_ROUND_EN for round-half-up output; default build truncates.
module bilinear_interp_2d #(
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = 2,
    parameter int NUM_CH    = 1,
    parameter int USER_W    = 1
) (
    input  logic               clk,
    input  logic               reset,
    bilinear_interp_2d_if.slave bus
);
    localparam int W1 = PIX_W + FRAC_BITS;
    localparam int W2 = PIX_W + 2 * FRAC_BITS;
    localparam logic [FRAC_BITS:0] S = {1'b1, {FRAC_BITS{1'b0}}};
`ifdef BILINEAR_ROUND_EN
    localparam logic [W2-1:0] RND = W2'(1) << (2 * FRAC_BITS - 1);
`else
    localparam logic [W2-1:0] RND = '0;
`endif

    logic                        valid1, valid2;
    logic                        ready1, ready2, ready3;
    logic [FRAC_BITS-1:0]        fy1;
    logic [USER_W-1:0]           user1, user2;
    logic [NUM_CH-1:0][W1-1:0]   top_q, bot_q, top_d, bot_d;
    logic [NUM_CH-1:0][W2-1:0]   acc_q, acc_d, rnd_sum;
    logic [NUM_CH*PIX_W-1:0]     out_d;
    logic [W1-1:0]               wx0, wx1;
    logic [W2-1:0]               wy0, wy1;

    // A stage can take new data if it is empty or its successor drains it.
    assign ready3       = !bus.out_valid || bus.out_ready;
    assign ready2       = !valid2 || ready3;
    assign ready1       = !valid1 || ready2;
    assign bus.in_ready = ready1;

    // NOTE: every output of this block is assigned on every pass (weights
    // first, then each channel's full word), so no latch can be inferred.
    always_comb begin
        wx0 = W1'(bus.in_frac_x);
        wx1 = W1'(S - {1'b0, bus.in_frac_x});
        wy0 = W2'(fy1);
        wy1 = W2'(S - {1'b0, fy1});
        for (int c = 0; c < NUM_CH; c++) begin
            top_d[c] = W1'(bus.in_pixels[(c*4+0)*PIX_W +: PIX_W]) * wx1
                     + W1'(bus.in_pixels[(c*4+1)*PIX_W +: PIX_W]) * wx0;
            bot_d[c] = W1'(bus.in_pixels[(c*4+2)*PIX_W +: PIX_W]) * wx1
                     + W1'(bus.in_pixels[(c*4+3)*PIX_W +: PIX_W]) * wx0;
            acc_d[c] = W2'(top_q[c]) * wy1 + W2'(bot_q[c]) * wy0;
            // Worst case (2^PIX_W-1)*S^2 + S^2/2 still fits in W2 bits.
            rnd_sum[c] = acc_q[c] + RND;
            out_d[c*PIX_W +: PIX_W] = rnd_sum[c][W2-1 -: PIX_W];
        end
    end

    // NOTE: non-blocking assignments throughout, so every stage samples the
    // previous stage's value from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are cleared too, so a reset leaves no
            // stale pixel visible on out_pixel or inside the pipe.
            valid1        <= 1'b0;
            valid2        <= 1'b0;
            bus.out_valid <= 1'b0;
            fy1           <= '0;
            user1         <= '0;
            user2         <= '0;
            top_q         <= '0;
            bot_q         <= '0;
            acc_q         <= '0;
            bus.out_pixel <= '0;
            bus.out_user  <= '0;
        end else begin
            if (ready1) begin
                valid1 <= bus.in_valid;
                if (bus.in_valid) begin
                    top_q <= top_d;
                    bot_q <= bot_d;
                    fy1   <= bus.in_frac_y;
                    user1 <= bus.in_user;
                end
            end
            if (ready2) begin
                valid2 <= valid1;
                if (valid1) begin
                    acc_q <= acc_d;
                    user2 <= user1;
                end
            end
            if (ready3) begin
                bus.out_valid <= valid2;
                if (valid2) begin
                    bus.out_pixel <= out_d;
                    bus.out_user  <= user2;
                end
            end
        end
    end
endmodule

// File: tb/tb_bilinear_interp_2d.sv
// Self-checking bench for bilinear_interp_2d: directed table, latency,
// backpressure, mid-stream reset and randomized traffic against a 2D model.
module tb_bilinear_interp_2d;
    localparam int PIX_W = 8;
    localparam int FB    = 2;
    localparam int NCH   = 3;
    localparam int UW    = 4;
    localparam int S     = 1 << FB;
`ifdef BILINEAR_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct packed {
        logic [NCH*PIX_W-1:0] pix;
        logic [UW-1:0]        user;
    } xfer_t;

    typedef struct {
        string                  name;
        logic [NCH*4*PIX_W-1:0] pix;
        logic [FB-1:0]          fx;
        logic [FB-1:0]          fy;
        logic [NCH*PIX_W-1:0]   exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bilinear_interp_2d_if #(.PIX_W(PIX_W), .FRAC_BITS(FB), .NUM_CH(NCH), .USER_W(UW)) bus ();

    bilinear_interp_2d #(.PIX_W(PIX_W), .FRAC_BITS(FB), .NUM_CH(NCH), .USER_W(UW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int    errors = 0;
    int    checks = 0;
    xfer_t exp_q[$];
    xfer_t cur_exp;
    string tag = "init";
    vec_t  vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [4*PIX_W-1:0] pack4(input logic [PIX_W-1:0] p0, p1, p2, p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic vec_t mkvec(input string n, input logic [NCH*4*PIX_W-1:0] pix,
                                   input logic [FB-1:0] fx, fy, input logic [NCH*PIX_W-1:0] e);
        vec_t v;
        v.name = n; v.pix = pix; v.fx = fx; v.fy = fy; v.exp = e;
        return v;
    endfunction

    // Direct 2D weighted sum of the four taps, then one exact division.
    function automatic logic [NCH*PIX_W-1:0] ref_model(input logic [NCH*4*PIX_W-1:0] pix,
                                                        input int fx, input int fy);
        logic [NCH*PIX_W-1:0] r;
        for (int c = 0; c < NCH; c++) begin
            int t[4];
            int sum;
            for (int k = 0; k < 4; k++) t[k] = int'(pix[(c*4+k)*PIX_W +: PIX_W]);
            sum = t[0]*(S-fx)*(S-fy) + t[1]*fx*(S-fy) + t[2]*(S-fx)*fy + t[3]*fx*fy;
            if (RND) sum += S*S/2;
            r[c*PIX_W +: PIX_W] = PIX_W'(sum / (S*S));
        end
        return r;
    endfunction

    // Called at the falling edge: transfers seen here complete on the next rise.
    task automatic sb_sample();
        xfer_t e;
        if (reset) return;
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'((exp_q.size() < 3) || bus.out_ready));
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_out"}, 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_pix"}, 64'(bus.out_pixel), 64'(e.pix));
                check({tag, "_user"}, 64'(bus.out_user), 64'(e.user));
            end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [NCH*4*PIX_W-1:0] pix,
                         input logic [FB-1:0] fx, fy, input logic [UW-1:0] user,
                         input logic [NCH*PIX_W-1:0] e);
        bus.in_valid  = v;
        bus.in_pixels = pix;
        bus.in_frac_x = fx;
        bus.in_frac_y = fy;
        bus.in_user   = user;
        cur_exp.pix   = e;
        cur_exp.user  = user;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
        check({tag, "_drain_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NCH*4*PIX_W-1:0] rpix;
        logic [PIX_W-1:0]       b;
        logic [NCH*PIX_W-1:0]   held_pix;
        logic [UW-1:0]          held_user;
        logic [FB-1:0]          rfx, rfy;
        int                     idx;

        vecs[0] = mkvec("mid", {3{pack4(8'd100, 8'd200, 8'd100, 8'd200)}}, 2'd2, 2'd0, {3{8'd150}});
        vecs[1] = mkvec("round", {3{pack4(8'd0, 8'd255, 8'd255, 8'd0)}}, 2'd2, 2'd2,
                        {3{RND ? 8'd128 : 8'd127}});
        vecs[2] = mkvec("full", {3{pack4(8'd255, 8'd255, 8'd255, 8'd255)}}, 2'd3, 2'd3, {3{8'd255}});
        vecs[3] = mkvec("zero", {3{pack4(8'd0, 8'd0, 8'd0, 8'd0)}}, 2'd1, 2'd2, {3{8'd0}});
        vecs[4] = mkvec("multi", {pack4(8'd7, 8'd7, 8'd7, 8'd7), pack4(8'd255, 8'd0, 8'd255, 8'd0),
                        pack4(8'd10, 8'd20, 8'd30, 8'd40)}, 2'd1, 2'd3,
                        {8'd7, 8'd191, RND ? 8'd28 : 8'd27});
        vecs[5] = mkvec("vert", {3{pack4(8'd0, 8'd0, 8'd255, 8'd255)}}, 2'd0, 2'd1,
                        {3{RND ? 8'd64 : 8'd63}});

        drive(1'b0, '0, '0, '0, '0, '0);
        do_reset();
        tag = "reset";
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_out_pixel", 64'(bus.out_pixel), 64'(0));
        check("reset_out_user", 64'(bus.out_user), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));

        // Latency: out_valid appears in the third cycle after the handshake.
        tag = "latency";
        bus.out_ready = 1'b1;
        drive(1'b1, vecs[0].pix, vecs[0].fx, vecs[0].fy, 4'd5, vecs[0].exp);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("latency_valid_c%0d", k), 64'(bus.out_valid), 64'(k == 3));
            sb_sample();
            @(posedge clk);
            #1;
        end
        drain();

        // Directed table, streamed back to back.
        tag = "table";
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tag = vecs[i].name;
            drive(1'b1, vecs[i].pix, vecs[i].fx, vecs[i].fy, UW'(i), vecs[i].exp);
            tick();
        end
        drain();

        // Backpressure: values 1..10, out_ready low for 5 cycles mid-stream.
        do_reset();
        tag = "bp";
        idx = 1;
        for (int cyc = 0; cyc < 40 && (idx <= 10 || exp_q.size() > 0); cyc++) begin
            b = PIX_W'(idx);
            rfx = FB'($urandom_range(0, S-1));
            rfy = FB'($urandom_range(0, S-1));
            drive(idx <= 10, {(NCH*4){b}}, rfx, rfy, UW'(idx), {NCH{b}});
            bus.out_ready = !(cyc >= 5 && cyc < 10);
            @(negedge clk);
            if (cyc == 5) begin
                held_pix  = bus.out_pixel;
                held_user = bus.out_user;
                check("bp_stall_valid", 64'(bus.out_valid), 64'(1));
            end else if (cyc > 5 && cyc < 10) begin
                check("bp_hold_pix", 64'(bus.out_pixel), 64'(held_pix));
                check("bp_hold_user", 64'(bus.out_user), 64'(held_user));
            end
            if (cyc == 9) check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
            if (!reset && bus.in_valid && bus.in_ready) idx++;
            sb_sample();
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(idx), 64'(11));
        drain();

        // Reset with three transfers in flight.
        do_reset();
        tag = "rst_mid";
        for (int i = 0; i < 3; i++) begin
            b = PIX_W'(50 + 10*i);
            drive(1'b1, {(NCH*4){b}}, 2'd1, 2'd1, UW'(i), {NCH{b}});
            tick();
        end
        check("rst_mid_full", 64'(bus.in_ready), 64'(0));
        reset = 1'b1;
        b = 8'd99;
        drive(1'b1, {(NCH*4){b}}, 2'd0, 2'd0, 4'd9, {NCH{b}});
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_out_pixel", 64'(bus.out_pixel), 64'(0));
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rst_mid_no_out", 64'(bus.out_valid), 64'(0));
            tick();
        end

        // Randomized traffic against the 2D reference model.
        do_reset();
        tag = "rand";
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH*4; k++) begin
                case ($urandom_range(0, 7))
                    0:       rpix[k*PIX_W +: PIX_W] = '0;
                    1:       rpix[k*PIX_W +: PIX_W] = '1;
                    default: rpix[k*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
                endcase
            end
            rfx = FB'($urandom_range(0, S-1));
            rfy = FB'($urandom_range(0, S-1));
            drive($urandom_range(0, 3) != 0, rpix, rfx, rfy, UW'($urandom_range(0, 15)),
                  ref_model(rpix, int'(rfx), int'(rfy)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
